// File: rtl/prince_bwd_half.sv
// PRINCE backward half: iterative engine running the five inverse rounds
// R6..R10 followed by the closing RC11/k1 addition. The state enters from
// the middle layer and leaves before the final k0' whitening.
`timescale 1ns/1ps

// Inverse linear layer M^-1 = M' o SR^-1: inverse ShiftRows first, then the
// involutive M' (block diagonal of M0_hat, M1_hat, M1_hat, M0_hat).
// Nibble 0 is bits 63:60; within a nibble the first matrix row is the MSB.
module imat (
    input  logic [63:0] din,
    output logic [63:0] dout
);

    function automatic logic [3:0] nib(input logic [63:0] x, input int idx);
        return x[63-4*idx -: 4];
    endfunction

    // Nibbles sit column-wise in a 4x4 matrix; row r is rotated right by r.
    function automatic logic [63:0] sr_inv(input logic [63:0] x);
        return {nib(x, 0),  nib(x, 13), nib(x, 10), nib(x, 7),
                nib(x, 4),  nib(x, 1),  nib(x, 14), nib(x, 11),
                nib(x, 8),  nib(x, 5),  nib(x, 2),  nib(x, 15),
                nib(x, 12), nib(x, 9),  nib(x, 6),  nib(x, 3)};
    endfunction

    // One 16x16 block: sub-block (i,j) is M_((i+j+base) mod 4), where M_m is
    // the 4x4 identity with row m cleared. base = 0 gives M0_hat, 1 gives M1_hat.
    function automatic logic [15:0] mhat(input logic [15:0] c, input logic [1:0] base);
        logic [15:0] r;
        logic [3:0]  n;
        logic [3:0]  mask;
        logic [1:0]  zr;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                zr   = 2'(i + j + int'(base));
                n    = c[15-4*j -: 4];
                mask = ~(4'b1000 >> zr);
                r[15-4*i -: 4] = r[15-4*i -: 4] ^ (n & mask);
            end
        end
        return r;
    endfunction

    logic [63:0] shifted;

    // Pure combinational linear layer.
    always_comb begin
        shifted = sr_inv(din);
        dout    = {mhat(shifted[63:48], 2'd0),
                   mhat(shifted[47:32], 2'd1),
                   mhat(shifted[31:16], 2'd1),
                   mhat(shifted[15:0],  2'd0)};
    end

endmodule

module prince_bwd_half (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] in_k1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [63:0] RC6  = 64'h7ef84f78fd955cb1;
    localparam logic [63:0] RC7  = 64'h85840851f1ac43aa;
    localparam logic [63:0] RC8  = 64'hc882d32f25323c54;
    localparam logic [63:0] RC9  = 64'h64a51195e0e3610d;
    localparam logic [63:0] RC10 = 64'hd3b5a399ca0c2399;
    localparam logic [63:0] RC11 = 64'hc0ac29b7c97c50dd;

    localparam logic [2:0] LAST_CNT = 3'd5;

    // cnt 0..4 selects the round constant of rounds 6..10; cnt 5 is the
    // closing addition, which reuses the same key-add path with RC11.
    function automatic logic [63:0] rc_sel(input logic [2:0] c);
        case (c)
            3'd0:    return RC6;
            3'd1:    return RC7;
            3'd2:    return RC8;
            3'd3:    return RC9;
            3'd4:    return RC10;
            default: return RC11;
        endcase
    endfunction

    function automatic logic [3:0] inv_s4(input logic [3:0] v);
        case (v)
            4'h0:    return 4'hb;
            4'h1:    return 4'h7;
            4'h2:    return 4'h3;
            4'h3:    return 4'h2;
            4'h4:    return 4'hf;
            4'h5:    return 4'hd;
            4'h6:    return 4'h8;
            4'h7:    return 4'h9;
            4'h8:    return 4'ha;
            4'h9:    return 4'h6;
            4'ha:    return 4'h4;
            4'hb:    return 4'h0;
            4'hc:    return 4'h5;
            4'hd:    return 4'he;
            4'he:    return 4'hc;
            default: return 4'h1;
        endcase
    endfunction

    function automatic logic [63:0] inv_s64(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[4*i +: 4] = inv_s4(x[4*i +: 4]);
        end
        return r;
    endfunction

    state_t      st;
    state_t      st_nxt;
    logic [2:0]  cnt;
    logic [63:0] state_r;
    logic [63:0] k1_r;
    logic [63:0] out_r;

    logic        load;
    logic        step;
    logic        finish;

    logic [63:0] rk_x;
    logic [63:0] lin_x;
    logic [63:0] round_x;

    // Key/constant addition shared by every round and the closing step.
    always_comb begin
        rk_x    = state_r ^ k1_r ^ rc_sel(cnt);
        round_x = inv_s64(lin_x);
    end

    imat u_imat (
        .din  (rk_x),
        .dout (lin_x)
    );

    // Next-state and handshake decode; in_ready never depends on in_valid.
    always_comb begin
        st_nxt   = st;
        in_ready = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        case (st)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load   = 1'b1;
                    st_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_CNT) begin
                    finish = 1'b1;
                    st_nxt = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load   = 1'b1;
                        st_nxt = RUN;
                    end else begin
                        st_nxt = IDLE;
                    end
                end
            end
            default: begin
                st_nxt = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    // Round datapath: load, iterate, then latch the result for the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 3'd0;
            state_r <= 64'h0;
            k1_r    <= 64'h0;
            out_r   <= 64'h0;
        end else if (load) begin
            cnt     <= 3'd0;
            state_r <= in_data;
            k1_r    <= in_k1;
        end else if (step) begin
            cnt     <= cnt + 3'd1;
            state_r <= round_x;
        end else if (finish) begin
            state_r <= rk_x;
            out_r   <= rk_x;
        end
    end

    assign out_valid = (st == DONE);
    assign out_data  = out_r;

endmodule

// File: tb/tb_prince_bwd_half.sv
// Directed bench for prince_bwd_half with an independent reference model.
`timescale 1ns/1ps

module tb_prince_bwd_half;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [63:0] in_k1;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    int total = 0;
    int bad   = 0;

    prince_bwd_half dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_k1     (in_k1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [63:0] m_rc(input int r);
        case (r)
            0:       return 64'h7ef84f78fd955cb1;
            1:       return 64'h85840851f1ac43aa;
            2:       return 64'hc882d32f25323c54;
            3:       return 64'h64a51195e0e3610d;
            4:       return 64'hd3b5a399ca0c2399;
            default: return 64'hc0ac29b7c97c50dd;
        endcase
    endfunction

    function automatic logic [63:0] m_invs(input logic [63:0] x);
        logic [63:0] tab;
        logic [63:0] o;
        int          v;
        tab = 64'hB732FD89A6405EC1;
        o   = '0;
        for (int i = 0; i < 16; i++) begin
            v = int'(x[63-4*i -: 4]);
            o[63-4*i -: 4] = tab[63-4*v -: 4];
        end
        return o;
    endfunction

    // Output at (row r, column c) takes input at (r, c - r mod 4).
    function automatic logic [63:0] m_srinv(input logic [63:0] x);
        logic [63:0] o;
        int          r, c, src;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            r   = i % 4;
            c   = i / 4;
            src = 4 * ((c - r + 4) % 4) + r;
            o[63-4*i -: 4] = x[63-4*src -: 4];
        end
        return o;
    endfunction

    // Each output bit is the parity of that bit column over the four nibbles
    // of its chunk, with the one nibble whose sub-block clears that row removed.
    function automatic logic [63:0] m_mp(input logic [63:0] x);
        logic [63:0] o;
        logic        p;
        int          base, jx;
        o = '0;
        for (int q = 0; q < 4; q++) begin
            base = (q == 1 || q == 2) ? 1 : 0;
            for (int i = 0; i < 4; i++) begin
                for (int k = 0; k < 4; k++) begin
                    p = 1'b0;
                    for (int j = 0; j < 4; j++) p = p ^ x[63-16*q-4*j-k];
                    jx = (k - i - base + 8) % 4;
                    o[63-16*q-4*i-k] = p ^ x[63-16*q-4*jx-k];
                end
            end
        end
        return o;
    endfunction

    function automatic logic [63:0] model(input logic [63:0] d, input logic [63:0] k);
        logic [63:0] s;
        s = d;
        for (int r = 0; r < 5; r++) begin
            s = s ^ k ^ m_rc(r);
            s = m_invs(m_mp(m_srinv(s)));
        end
        return s ^ k ^ m_rc(5);
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Launches one block from IDLE, checks the six RUN cycles and the result.
    task automatic do_block(input logic [63:0] d, input logic [63:0] k,
                            input bit zero_k, input string tag);
        logic [63:0] exp;
        bit          run_ok;
        exp    = model(d, k);
        run_ok = 1'b1;
        in_data  = d;
        in_k1    = k;
        in_valid = 1'b1;
        check1({tag, "_accept_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        in_data  = 64'h0;
        if (zero_k) in_k1 = 64'h0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b0) run_ok = 1'b0;
            tick();
        end
        check1({tag, "_run_quiet"}, run_ok, 1'b1);
        check1({tag, "_valid_lat6"}, out_valid, 1'b1);
        check64({tag, "_data"}, out_data, exp);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [63:0] held;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
        bit          ok;
        int          gap;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 64'h0;
        in_k1     = 64'h0;
        out_ready = 1'b0;

        // Reset then idle
        tick();
        tick();
        rst = 1'b0;
        check1("rst_out_valid", out_valid, 1'b0);
        check64("rst_out_data", out_data, 64'h0);
        check1("rst_in_ready", in_ready, 1'b1);
        ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
        end
        check1("idle_quiet", ok, 1'b1);

        // Single block with zero key
        out_ready = 1'b1;
        do_block(64'h0123456789abcdef, 64'h0, 1'b0, "single");
        check1("single_done_ready", in_ready, 1'b1);
        tick();
        check1("single_valid_fall", out_valid, 1'b0);
        check1("single_idle_ready", in_ready, 1'b1);

        // Key captured at load, then in_k1 cleared during RUN
        do_block(64'hffffffffffffffff, 64'hfedcba9876543210, 1'b1, "keycap");
        tick();
        check1("keycap_valid_fall", out_valid, 1'b0);

        // Backpressure
        out_ready = 1'b0;
        do_block(64'h0f1e2d3c4b5a6978, 64'h1122334455667788, 1'b0, "bp");
        held = model(64'h0f1e2d3c4b5a6978, 64'h1122334455667788);
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) ok = 1'b0;
        end
        check1("bp_hold", ok, 1'b1);
        out_ready = 1'b1;
        #1;
        check1("bp_ready_comb", in_ready, 1'b1);
        tick();
        check1("bp_valid_fall", out_valid, 1'b0);
        check64("bp_data_kept", out_data, held);

        // Back-to-back with in_valid held high
        exp_a = model(64'h0, 64'h0123456789abcdef);
        exp_b = model(64'h1, 64'h0123456789abcdef);
        in_k1    = 64'h0123456789abcdef;
        in_data  = 64'h0;
        in_valid = 1'b1;
        tick();
        in_data = 64'h1;
        for (int c = 0; c < 6; c++) tick();
        check1("b2b_a_valid", out_valid, 1'b1);
        check64("b2b_a_data", out_data, exp_a);
        check1("b2b_a_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check1("b2b_b_taken", in_ready, 1'b0);
        gap = 1;
        while (out_valid !== 1'b1 && gap < 20) begin
            tick();
            gap++;
        end
        check64("b2b_gap", 64'(gap), 64'd7);
        check64("b2b_b_data", out_data, exp_b);
        tick();
        check1("b2b_b_fall", out_valid, 1'b0);

        // Reset mid-run at cnt = 3
        in_data  = 64'hdeadbeefcafef00d;
        in_k1    = 64'h5555aaaa5555aaaa;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check1("midrst_ready", in_ready, 1'b1);
        check1("midrst_valid", out_valid, 1'b0);
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid !== 1'b0) ok = 1'b0;
        end
        check1("midrst_no_output", ok, 1'b1);
        do_block(64'h8000000000000001, 64'hffff0000ffff0000, 1'b0, "after_rst");
        tick();

        // Reset together with in_valid: nothing loaded
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'h1234;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check1("rstvld_ready", in_ready, 1'b1);
        ok = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
        end
        check1("rstvld_no_load", ok, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
